// File: rtl/reg_file_arbiter.sv
// Round-robin req/gnt/rvalid arbiter sharing the reg_file index/write port between core (A) and debug (B).
// Optional post-reset zeroing of all registers is built when REGFILE_CLEAR_EN is defined.
module reg_file_arbiter #(
  parameter int DATA_W   = 16,
  parameter int IDX_W    = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [IDX_W-1:0]  a_idx,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [IDX_W-1:0]  b_idx,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [IDX_W-1:0]  rf_index1,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              rf_we,
  input  logic [DATA_W-1:0] rf_rdata1,
  output logic              clear_busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_CLEAR  = 2'd2
  } state_e;

`ifdef REGFILE_CLEAR_EN
  localparam int CNT_W = $clog2(NUM_REGS + 1);
  localparam logic [CNT_W-1:0] CLR_END = CNT_W'(NUM_REGS);
  localparam state_e RST_STATE = ST_CLEAR;
  logic [CNT_W-1:0] clr_cnt_q, clr_cnt_d;
  logic             clear_busy_q, clear_busy_d;
`else
  localparam state_e RST_STATE = ST_IDLE;
`endif

  state_e            state_q, state_d;
  logic              last_b_q, last_b_d;
  logic              a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
  logic              a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic [IDX_W-1:0]  rf_index1_q, rf_index1_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic              rf_we_q, rf_we_d;

  // Next-state and next-output logic; the winner's gnt/rf_we registers double as the captured access
  always_comb begin
    state_d     = state_q;
    last_b_d    = last_b_q;
    a_gnt_d     = 1'b0;
    b_gnt_d     = 1'b0;
    a_rvalid_d  = 1'b0;
    b_rvalid_d  = 1'b0;
    a_rdata_d   = a_rdata_q;
    b_rdata_d   = b_rdata_q;
    rf_index1_d = rf_index1_q;
    rf_wdata_d  = rf_wdata_q;
    rf_we_d     = 1'b0;
`ifdef REGFILE_CLEAR_EN
    clr_cnt_d    = clr_cnt_q;
    clear_busy_d = clear_busy_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (a_req && (!b_req || last_b_q)) begin
          rf_index1_d = a_idx;
          rf_wdata_d  = a_wdata;
          rf_we_d     = a_we;
          a_gnt_d     = 1'b1;
          last_b_d    = 1'b0;
          state_d     = ST_ACCESS;
        end else if (b_req) begin
          rf_index1_d = b_idx;
          rf_wdata_d  = b_wdata;
          rf_we_d     = b_we;
          b_gnt_d     = 1'b1;
          last_b_d    = 1'b1;
          state_d     = ST_ACCESS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        state_d = ST_IDLE;
        if (!rf_we_q && a_gnt_q) begin
          a_rvalid_d = 1'b1;
          a_rdata_d  = rf_rdata1;
        end else if (!rf_we_q && b_gnt_q) begin
          b_rvalid_d = 1'b1;
          b_rdata_d  = rf_rdata1;
        end else begin
          a_rvalid_d = 1'b0;
        end
      end
`ifdef REGFILE_CLEAR_EN
      ST_CLEAR: begin
        if (clr_cnt_q == CLR_END) begin
          clear_busy_d = 1'b0;
          state_d      = ST_IDLE;
        end else begin
          rf_index1_d = IDX_W'(clr_cnt_q);
          rf_wdata_d  = {DATA_W{1'b0}};
          rf_we_d     = 1'b1;
          clr_cnt_d   = clr_cnt_q + CNT_W'(1);
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any in-flight write at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RST_STATE;
      last_b_q    <= 1'b1;
      a_gnt_q     <= 1'b0;
      b_gnt_q     <= 1'b0;
      a_rvalid_q  <= 1'b0;
      b_rvalid_q  <= 1'b0;
      a_rdata_q   <= {DATA_W{1'b0}};
      b_rdata_q   <= {DATA_W{1'b0}};
      rf_index1_q <= {IDX_W{1'b0}};
      rf_wdata_q  <= {DATA_W{1'b0}};
      rf_we_q     <= 1'b0;
`ifdef REGFILE_CLEAR_EN
      clr_cnt_q    <= {CNT_W{1'b0}};
      clear_busy_q <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      last_b_q    <= last_b_d;
      a_gnt_q     <= a_gnt_d;
      b_gnt_q     <= b_gnt_d;
      a_rvalid_q  <= a_rvalid_d;
      b_rvalid_q  <= b_rvalid_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
      rf_index1_q <= rf_index1_d;
      rf_wdata_q  <= rf_wdata_d;
      rf_we_q     <= rf_we_d;
`ifdef REGFILE_CLEAR_EN
      clr_cnt_q    <= clr_cnt_d;
      clear_busy_q <= clear_busy_d;
`endif
    end
  end

  assign a_gnt     = a_gnt_q;
  assign b_gnt     = b_gnt_q;
  assign a_rvalid  = a_rvalid_q;
  assign b_rvalid  = b_rvalid_q;
  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;
  assign rf_index1 = rf_index1_q;
  assign rf_wdata  = rf_wdata_q;
  assign rf_we     = rf_we_q;
`ifdef REGFILE_CLEAR_EN
  assign clear_busy = clear_busy_q;
`else
  assign clear_busy = 1'b0;
`endif

endmodule
